// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end for the single-port RAM: deserialises 10-bit command words
// from MOSI and serialises RAM read data MSB-first on MISO.
module spi_slave_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int RX_W  = DATA_W + 2;
    localparam int CNT_W = $clog2(RX_W + 1);
    localparam int OUT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [RX_W-2:0]     r_shift;
    logic [RX_W-1:0]     r_rx_data;
    logic                r_rx_valid;
    logic                r_rd_addr_done;
    logic                r_wait_tx;
    logic [DATA_W-2:0]   r_tx_shift;
    logic [OUT_W-1:0]    r_out_cnt;
    logic                r_miso;
    logic                w_data_state;
    logic                w_shift_en;
    logic                w_word_done;
    logic                w_capture;

    // Shift/complete/capture qualifiers derived from the current state
    always_comb begin
        w_data_state = (r_state == ST_WRITE) || (r_state == ST_READ_ADD) ||
                       (r_state == ST_READ_DATA);
        w_shift_en   = (ss_n == 1'b0) &&
                       ((r_state == ST_CHK_CMD) ||
                        (w_data_state && (r_bit_cnt < CNT_W'(RX_W))));
        w_word_done  = (ss_n == 1'b0) && w_data_state &&
                       (r_bit_cnt == CNT_W'(RX_W - 1));
        w_capture    = (ss_n == 1'b0) && (r_state == ST_READ_DATA) &&
                       r_wait_tx && tx_valid;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a deselect from any state returns to IDLE
    always_comb begin
        w_next_state = r_state;
        if (ss_n == 1'b1) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_CHK_CMD;
                end
                ST_CHK_CMD: begin
                    if (mosi == 1'b0) begin
                        w_next_state = ST_WRITE;
                    end else if (r_rd_addr_done) begin
                        w_next_state = ST_READ_DATA;
                    end else begin
                        w_next_state = ST_READ_ADD;
                    end
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    w_next_state = r_state;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Receive shifter; the counter saturates at RX_W so trailing bits are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (ss_n == 1'b1) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {r_shift[RX_W-3:0], mosi};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_word_done) begin
                r_rx_data  <= {r_shift, mosi};
                r_rx_valid <= 1'b1;
            end
        end
    end

    // Read-address flag survives aborts; only completed read words move it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr_done <= 1'b0;
            r_wait_tx      <= 1'b0;
        end else if (ss_n == 1'b1) begin
            r_wait_tx <= 1'b0;
        end else if (w_word_done && (r_state == ST_READ_ADD)) begin
            r_rd_addr_done <= 1'b1;
        end else if (w_word_done && (r_state == ST_READ_DATA)) begin
            r_rd_addr_done <= 1'b0;
            r_wait_tx      <= 1'b1;
        end else if (w_capture) begin
            r_wait_tx <= 1'b0;
        end
    end

    // MISO serialiser: MSB goes out on the capture edge, then one bit per edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift <= '0;
            r_out_cnt  <= '0;
            r_miso     <= 1'b0;
        end else if (ss_n == 1'b1) begin
            r_tx_shift <= '0;
            r_out_cnt  <= '0;
            r_miso     <= 1'b0;
        end else if (w_capture) begin
            r_tx_shift <= tx_data[DATA_W-2:0];
            r_out_cnt  <= OUT_W'(DATA_W - 1);
            r_miso     <= tx_data[DATA_W-1];
        end else if (r_out_cnt != OUT_W'(0)) begin
            r_miso     <= r_tx_shift[DATA_W-2];
            r_tx_shift <= {r_tx_shift[DATA_W-3:0], 1'b0};
            r_out_cnt  <= r_out_cnt - OUT_W'(1);
        end else begin
            r_miso <= 1'b0;
        end
    end

    assign miso     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl with a behavioural single-port RAM model.
module tb_spi_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    logic [7:0] mem [256];
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] ram_tx_data = 8'h00;
    logic       ram_tx_valid = 1'b0;
    logic       force_tx = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int rv_cnt = 0;
    int rv_snap;
    logic [7:0] exp_b;

    spi_slave_ctrl #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    assign tx_valid = ram_tx_valid | force_tx;
    assign tx_data  = force_tx ? 8'hFF : ram_tx_data;

    // RAM model: 00 write addr, 01 write data, 10 read addr, 11 read data
    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (rx_valid) begin
            rv_cnt <= rv_cnt + 1;
            case (rx_data[9:8])
                2'b00:   wr_addr <= rx_data[7:0];
                2'b01:   mem[wr_addr] <= rx_data[7:0];
                2'b10:   rd_addr <= rx_data[7:0];
                default: begin
                    ram_tx_data  <= mem[rd_addr];
                    ram_tx_valid <= 1'b1;
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [9:0] w, input int n);
        ss_n = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            mosi = w[9-i];
            tick();
        end
    endtask

    // Full frame: rx_valid must be low after 9 data edges and high after the 10th
    task automatic frame_word(input string tag, input logic [9:0] w);
        send_bits(w, 9);
        chk({tag, "_early"}, {31'd0, rx_valid}, 32'd0);
        mosi = w[0];
        tick();
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        chk({tag, "_data"}, {22'd0, rx_data}, {22'd0, w});
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0;
        #12;
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_rxv", {31'd0, rx_valid}, 32'd0);
        chk("rst_rxd", {22'd0, rx_data}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: reset in the middle of a write frame
        send_bits(10'h0FF, 5);
        rst = 1'b1;
        #2;
        chk("t1_miso", {31'd0, miso}, 32'd0);
        chk("t1_rxv", {31'd0, rx_valid}, 32'd0);
        chk("t1_state", {29'd0, dut.r_state}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ss_n = 1'b1;
        tick();
        rv_snap = rv_cnt;
        frame_word("t1_f", 10'h010);
        end_frame();
        chk("t1_clr", {31'd0, rx_valid}, 32'd0);
        chk("t1_pulses", rv_cnt - rv_snap, 32'd1);

        // 2: write address then write data
        rv_snap = rv_cnt;
        frame_word("t2_a", 10'h03A);
        end_frame();
        frame_word("t2_d", 10'h1C5);
        end_frame();
        chk("t2_pulses", rv_cnt - rv_snap, 32'd2);
        chk("t2_flag", {31'd0, dut.r_rd_addr_done}, 32'd0);

        // 3: read address then read data, RAM returns 0xC5
        frame_word("t3_a", 10'h23A);
        end_frame();
        chk("t3_flag_set", {31'd0, dut.r_rd_addr_done}, 32'd1);
        frame_word("t3_d", 10'h300);
        tick();
        chk("t3_miso_n1", {31'd0, miso}, 32'd0);
        exp_b = 8'hC5;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t3_bit%0d", 7 - i), {31'd0, miso}, {31'd0, exp_b[7-i]});
        end
        tick();
        chk("t3_tail", {31'd0, miso}, 32'd0);
        chk("t3_flag_clr", {31'd0, dut.r_rd_addr_done}, 32'd0);
        end_frame();

        // 4: abort a read-address frame after 6 bits
        rv_snap = rv_cnt;
        send_bits(10'h23A, 6);
        end_frame();
        chk("t4_nopulse", rv_cnt - rv_snap, 32'd0);
        chk("t4_flag", {31'd0, dut.r_rd_addr_done}, 32'd0);
        frame_word("t4_ra", 10'h23A);
        chk("t4_state", {29'd0, dut.r_state}, 32'd3);
        end_frame();
        chk("t4_flag_set", {31'd0, dut.r_rd_addr_done}, 32'd1);
        frame_word("t4_rd", 10'h300);
        end_frame();
        tick();
        chk("t4_miso_idle", {31'd0, miso}, 32'd0);

        // 5: abort during readback of 0xA5
        frame_word("t5_wa", 10'h010);
        end_frame();
        frame_word("t5_wd", 10'h1A5);
        end_frame();
        frame_word("t5_ra", 10'h210);
        end_frame();
        frame_word("t5_rd", 10'h300);
        tick();
        tick();
        chk("t5_b7", {31'd0, miso}, 32'd1);
        tick();
        chk("t5_b6", {31'd0, miso}, 32'd0);
        tick();
        chk("t5_b5", {31'd0, miso}, 32'd1);
        end_frame();
        chk("t5_abort_miso", {31'd0, miso}, 32'd0);
        chk("t5_abort_state", {29'd0, dut.r_state}, 32'd0);
        tick();
        chk("t5_miso_hold", {31'd0, miso}, 32'd0);
        frame_word("t5_next", 10'h2AB);
        chk("t5_next_state", {29'd0, dut.r_state}, 32'd3);
        end_frame();

        // 6: spurious tx_valid in IDLE and during a write frame
        force_tx = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_idle_miso", {31'd0, miso}, 32'd0);
            chk("t6_idle_state", {29'd0, dut.r_state}, 32'd0);
        end
        ss_n = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            mosi = exp_b[0];
            exp_b = 8'h55;
            mosi = (i < 2) ? 1'b0 : exp_b[9-i];
            tick();
            chk("t6_wr_miso", {31'd0, miso}, 32'd0);
        end
        chk("t6_data", {22'd0, rx_data}, 32'h055);
        chk("t6_state", {29'd0, dut.r_state}, 32'd2);
        end_frame();
        force_tx = 1'b0;
        chk("t6_end_miso", {31'd0, miso}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
